// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : Core-to-data-memory bus with initiator and responder views.
// Revision : 1.0
// ============================================================================
interface data_mem_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Err;

    modport master (
        output MemWrite, MemRead, DataAdr, WriteData,
        input  ReadData, Ready, Err
    );

    modport slave (
        input  MemWrite, MemRead, DataAdr, WriteData,
        output ReadData, Ready, Err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Word-addressed data RAM with wait-state latency, one-cycle Ready
//            pulse and error reporting for misaligned/out-of-range/conflicts.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH   = 64,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    data_mem_responder_if.slave  bus
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [c_AW-1:0]   idx_q;
    logic [31:0]       data_q;
    logic              wr_q;
    logic              rd_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [DEPTH];

    logic              w_req;
    logic [31:0]       w_off;
    logic              w_err;
    logic [c_AW-1:0]   w_idx;
    logic              w_capture;
    logic              w_commit;
    logic              w_c_wr;
    logic              w_c_rd;
    logic              w_c_err;
    logic [c_AW-1:0]   w_c_idx;
    logic [31:0]       w_c_data;

    // Range check works on the unwrapped 32-bit offset before truncation to an index.
    assign w_req = bus.MemWrite | bus.MemRead;
    assign w_off = bus.DataAdr - BASE;
    assign w_err = (bus.DataAdr[1:0] != 2'b00)
                 | (bus.DataAdr < BASE)
                 | ((w_off >> 2) >= 32'(DEPTH))
                 | (bus.MemWrite & bus.MemRead);
    assign w_idx = w_off[c_AW+1:2];

    // With LATENCY=1 the commit edge is the sample edge, so live fields are used.
    assign w_c_wr   = (state_q == S_IDLE) ? bus.MemWrite  : wr_q;
    assign w_c_rd   = (state_q == S_IDLE) ? bus.MemRead   : rd_q;
    assign w_c_err  = (state_q == S_IDLE) ? w_err         : err_q;
    assign w_c_idx  = (state_q == S_IDLE) ? w_idx         : idx_q;
    assign w_c_data = (state_q == S_IDLE) ? bus.WriteData : data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_capture = 1'b0;
        w_commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d  = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        cnt_d   = c_CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_RESP;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_capture) begin
                idx_q  <= w_idx;
                data_q <= bus.WriteData;
                wr_q   <= bus.MemWrite;
                rd_q   <= bus.MemRead;
                err_q  <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (w_commit) begin
            if (w_c_err) begin
                if (w_c_rd) begin
                    rdata_q <= 32'd0;
                end
            end else if (w_c_wr) begin
                mem_q[w_c_idx] <= w_c_data;
            end else if (w_c_rd) begin
                rdata_q <= mem_q[w_c_idx];
            end
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.Ready    = (state_q == S_RESP);
    assign bus.Err      = (state_q == S_RESP) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder at LATENCY 2, 4 and 1.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam int          c_DEPTH = 64;
    localparam logic [31:0] c_BASE  = 32'h0;

    logic clk;
    logic reset2, reset4, reset1;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] model_mem [3][c_DEPTH];
    logic [31:0] model_rd  [3];

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus4 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH(c_DEPTH), .LATENCY(2), .BASE(c_BASE)) u_dut2 (
        .clk(clk), .reset(reset2), .bus(bus2.slave));
    data_mem_responder #(.DEPTH(c_DEPTH), .LATENCY(4), .BASE(c_BASE)) u_dut4 (
        .clk(clk), .reset(reset4), .bus(bus4.slave));
    data_mem_responder #(.DEPTH(c_DEPTH), .LATENCY(1), .BASE(c_BASE)) u_dut1 (
        .clk(clk), .reset(reset1), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int inst_idx(input int sel);
        return (sel == 2) ? 0 : (sel == 4) ? 1 : 2;
    endfunction

    task automatic drive(input int sel, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        case (sel)
            2: begin bus2.MemWrite = we; bus2.MemRead = re; bus2.DataAdr = a; bus2.WriteData = d; end
            4: begin bus4.MemWrite = we; bus4.MemRead = re; bus4.DataAdr = a; bus4.WriteData = d; end
            default: begin bus1.MemWrite = we; bus1.MemRead = re; bus1.DataAdr = a; bus1.WriteData = d; end
        endcase
    endtask

    // {Ready, Err, ReadData}
    function automatic logic [33:0] outs(input int sel);
        case (sel)
            2:       return {bus2.Ready, bus2.Err, bus2.ReadData};
            4:       return {bus4.Ready, bus4.Err, bus4.ReadData};
            default: return {bus1.Ready, bus1.Err, bus1.ReadData};
        endcase
    endfunction

    function automatic logic model_err(input logic we, input logic re, input logic [31:0] a);
        logic [31:0] off;
        off = a - c_BASE;
        return (a % 4 != 0) || (a < c_BASE) || ((off / 4) >= c_DEPTH) || (we && re);
    endfunction

    task automatic model_reset(input int mi);
        for (int i = 0; i < c_DEPTH; i++) model_mem[mi][i] = 32'd0;
        model_rd[mi] = 32'd0;
    endtask

    // Apply the spec's effect of one access to the model; returns expected Err.
    task automatic model_apply(input int mi, input logic we, input logic re,
                               input logic [31:0] a, input logic [31:0] d, output logic e);
        int idx;
        e   = model_err(we, re, a);
        idx = int'((a - c_BASE) / 4);
        if (e) begin
            if (re) model_rd[mi] = 32'd0;
        end else if (we) begin
            model_mem[mi][idx] = d;
        end else if (re) begin
            model_rd[mi] = model_mem[mi][idx];
        end
    endtask

    // One full handshake; called just after a rising edge.
    task automatic access(input int sel, input int lat, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] d, input string name);
        logic        e_err;
        logic [33:0] o;
        int          cycles;
        bit          got;
        int          mi;
        mi = inst_idx(sel);
        model_apply(mi, we, re, a, d, e_err);
        drive(sel, we, re, a, d);
        cycles = 0;
        got    = 0;
        o      = '0;
        while (!got && cycles < 40) begin
            @(negedge clk);
            o = outs(sel);
            if (o[33]) begin
                got = 1;
            end else begin
                checks++;
                if (o[32] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s err_without_ready: got Err=%b want 0", name, o[32]);
                end
                cycles++;
            end
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no Ready after %0d cycles", name, cycles);
        end else begin
            if (cycles !== lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, cycles, lat);
            end
            checks++;
            if (o[32] !== e_err) begin
                errors++;
                $display("FAIL %s err: got %b want %b", name, o[32], e_err);
            end
            checks++;
            if (o[31:0] !== model_rd[mi]) begin
                errors++;
                $display("FAIL %s rdata: got %h want %h", name, o[31:0], model_rd[mi]);
            end
        end
    endtask

    task automatic test_reset();
        logic [33:0] o;
        reset2 = 1'b0; reset4 = 1'b0; reset1 = 1'b0;
        drive(2, 0, 0, 0, 0); drive(4, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
        for (int m = 0; m < 3; m++) model_reset(m);
        #3;
        for (int s = 0; s < 3; s++) begin
            o = outs((s == 0) ? 2 : (s == 1) ? 4 : 1);
            checks++;
            if (o !== 34'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h want 0", s, o);
            end
        end
        #9;
        reset2 = 1'b1; reset4 = 1'b1; reset1 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        access(2, 2, 1, 0, 32'd108, 32'h3FFF_FFFF, "basic_wr108");
        access(2, 2, 0, 1, 32'd108, 32'd0, "basic_rd108");
    endtask

    task automatic test_back_to_back();
        access(2, 2, 1, 0, 32'd100, 32'h11, "b2b_wr100");
        access(2, 2, 1, 0, 32'd104, 32'h22, "b2b_wr104");
        access(2, 2, 1, 0, 32'd108, 32'h33, "b2b_wr108");
        access(2, 2, 0, 1, 32'd100, 32'd0, "b2b_rd100");
        access(2, 2, 0, 1, 32'd104, 32'd0, "b2b_rd104");
        access(2, 2, 0, 1, 32'd108, 32'd0, "b2b_rd108");
    endtask

    task automatic test_errors();
        access(2, 2, 0, 1, 32'h66, 32'd0, "err_misaligned_rd");
        access(2, 2, 0, 1, 32'd100, 32'd0, "err_reload_rd100");
        access(2, 2, 1, 0, 32'd256, 32'hCAFE_F00D, "err_range_wr256");
        access(2, 2, 0, 1, 32'd0, 32'd0, "err_noalias_rd0");
        access(2, 2, 0, 1, 32'd104, 32'd0, "err_reload_rd104");
        access(2, 2, 1, 1, 32'd8, 32'h1234_5678, "err_conflict");
        access(2, 2, 0, 1, 32'd8, 32'd0, "err_conflict_rd8");
        access(2, 2, 0, 1, 32'hFFFF_FFFC, 32'd0, "err_range_high");
    endtask

    task automatic test_random();
        logic [31:0]  a, d;
        logic         we, re;
        int unsigned  r, op;
        for (int n = 0; n < 60; n++) begin
            r  = $urandom % 8;
            op = $urandom % 5;
            d  = $urandom;
            if (r < 5)       a = ($urandom % 64) * 4;
            else if (r == 5) a = ($urandom % 64) * 4 + 1 + ($urandom % 3);
            else if (r == 6) a = 256 + ($urandom % 4096) * 4;
            else             a = 32'hFFFF_FFFC - ($urandom % 16) * 4;
            we = (op < 2) || (op == 4);
            re = (op >= 2);
            access(2, 2, we, re, a, d, "random");
        end
    endtask

    task automatic test_latency4_reset();
        logic [33:0] o;
        access(4, 4, 1, 0, 32'd20, 32'h5A, "lat4_wr20");
        access(4, 4, 0, 1, 32'd20, 32'd0, "lat4_rd20");
        drive(4, 1, 0, 32'd16, 32'hDEAD_BEEF);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        #1;
        o = outs(4);
        checks++;
        if (o !== 34'd0) begin
            errors++;
            $display("FAIL lat4_async_reset: got %h want 0", o);
        end
        drive(4, 0, 0, 32'd0, 32'd0);
        model_reset(inst_idx(4));
        #2;
        reset4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus4.Ready !== 1'b0) begin
                errors++;
                $display("FAIL lat4_aborted_ready cycle%0d: got %b want 0", k, bus4.Ready);
            end
        end
        @(posedge clk);
        #1;
        access(4, 4, 0, 1, 32'd16, 32'd0, "lat4_rd16_after_reset");
        access(4, 4, 0, 1, 32'd20, 32'd0, "lat4_rd20_after_reset");
    endtask

    task automatic test_latency1_stream();
        logic exp_ready;
        access(1, 1, 1, 0, 32'd4, 32'h77, "lat1_wr4");
        access(1, 1, 0, 1, 32'd12, 32'd0, "lat1_rd12");
        drive(1, 0, 1, 32'd4, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_ready = (k % 2 == 1);
            checks++;
            if (bus1.Ready !== exp_ready) begin
                errors++;
                $display("FAIL lat1_stream_ready cycle%0d: got %b want %b", k, bus1.Ready, exp_ready);
            end
            if (exp_ready) begin
                checks++;
                if (bus1.ReadData !== 32'h77 || bus1.Err !== 1'b0) begin
                    errors++;
                    $display("FAIL lat1_stream_data cycle%0d: got %h/%b want 00000077/0",
                             k, bus1.ReadData, bus1.Err);
                end
            end
        end
        @(posedge clk);
        #1;
        drive(1, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_random();
        test_latency4_reset();
        test_latency1_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the multi-cycle RISC-V core's data bus: the reader/acceptor of the core's `MemWrite`/`DataAdr`/`WriteData` stores, plus loads.
- Word-addressed RAM with a configurable wait-state latency and a one-cycle `Ready` handshake, so the core's FSM can stall on memory.
- Replaces the zero-latency data memory inside `top`. Reports misaligned, out-of-range and conflicting accesses on `Err`.

Parameters:
- DEPTH, 64: number of 32-bit words; legal range 2..1024, power of two.
- LATENCY, 2: cycles from request sample to `Ready`; legal range 1..15.
- BASE, 0: byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- DataAdr  in  32  byte address of the access.
- WriteData  in  32  store data.
- ReadData  out  32  load data; registered.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  error flag; valid only while `Ready`=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, `Ready`=0, `Err`=0, `ReadData`=0, all RAM words cleared to 0, counter=0. Takes effect immediately, not at the next edge.
- Reset during WAIT or RESP aborts the transaction: no pending write is committed, no `Ready` is issued.
- States: IDLE, WAIT, RESP.
- IDLE: `Ready`=0.
  - On a rising edge with `MemWrite`|`MemRead`=1, capture the address, data, op and error status.
  - LATENCY=1: go to RESP.
  - LATENCY>1: load counter=LATENCY-2 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT: requests are ignored. Decrement counter each edge; on the edge where counter==0, go to RESP.
- Commit point: the edge entering RESP.
  - Legal write: `mem[(adr-BASE)>>2] <= data`.
  - Legal read: `ReadData <= mem[index]`.
- RESP: `Ready`=1 for exactly one cycle, then IDLE unconditionally.
- Latency: request sampled at edge E0; `Ready` is high during the cycle after edge E0+LATENCY-1. That is, `Ready` is asserted LATENCY cycles after the request is first presented.
- Handshake rules:
  - The initiator holds the request and its fields stable until it samples `Ready`=1, then deasserts on that same edge.
  - A request still asserted in the IDLE cycle following RESP is treated as a new transaction. Minimum spacing is one IDLE cycle between transactions.
- `ReadData` holds its last load value between loads. Writes and errored accesses do not alter it, except that an errored read sets it to 0.
- Error conditions, captured at the sample edge:
  - `DataAdr[1:0]`!=0 (misaligned);
  - DataAdr<BASE or (DataAdr-BASE)>>2 >= DEPTH (out of range; 32-bit unsigned compare, no wrap);
  - `MemWrite`&`MemRead` both 1 (conflict).
- On error: same latency, no RAM access, `Err`=1 together with `Ready`; if the op includes a read, `ReadData`<=0. `Err`=0 whenever `Ready`=0.
- Address-to-index arithmetic uses 32-bit subtraction; only the low log2(DEPTH) bits of the index address the RAM after the range check passes.

Test Plan:
- LATENCY=2, BASE=0: write 0x3FFFFFFF to addr 108 (request at cycle 0) -> `Ready`=1 at cycle 2, `Err`=0; then read 108 -> `Ready` 2 cycles after the request, `ReadData`=0x3FFFFFFF.
- Writes to 100=0x11, 104=0x22, 108=0x33 back-to-back, each dropped on `Ready`, then read all three -> 0x11, 0x22, 0x33; exactly one `Ready` per access, with one IDLE cycle between accesses.
- Read addr 0x66 (misaligned) -> `Ready`&`Err` at the latency cycle, `ReadData`=0. Write addr 256 with DEPTH=64 -> `Err`=1, and a later read of word 0 still returns 0 (no aliasing).
- `MemWrite`=`MemRead`=1 at addr 8 -> `Err`=1, `ReadData`=0, `mem[2]` unchanged (read back = 0).
- LATENCY=4: write 0xDEADBEEF to addr 16, pull reset low during WAIT (cycle 2) for 3 ns, then release -> `Ready` never pulses for that request, outputs go 0 asynchronously, and a read of 16 returns 0.
- LATENCY=1: hold `MemRead` at addr 4 high continuously -> `Ready` pulses every other cycle (RESP, IDLE, RESP...), and each response returns `mem[1]`.
